// File: rtl/spi_pkg.sv
// spi_pkg: shared state encoding and default widths for the SPI controller blocks
package spi_pkg;
    localparam int SPI_DIV_W = 8;
    localparam int SPI_CNT_W = 6;
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_TAIL} spi_state_e;
endpackage

// File: rtl/spi_tick_counter.sv
// spi_tick_counter: loadable 0..max_i counter with a wrap pulse on the terminal count
module spi_tick_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic         en_i,
    input  logic [W-1:0] max_i,
    output logic         wrap_o
);
    logic [W-1:0] cnt_q, cnt_d;
    assign wrap_o = en_i & ~load_i & (cnt_q == max_i);
    always_comb cnt_d = (load_i | wrap_o) ? '0 : en_i ? cnt_q + 1'b1 : cnt_q;
    always_ff @(posedge clk)
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
endmodule

// File: rtl/spi_sclk_gen.sv
// spi_sclk_gen: programmable burst SCLK generator with CPOL/CPHA shift and sample strobes
module spi_sclk_gen
    import spi_pkg::*;
#(
    parameter int DIV_W = SPI_DIV_W,
    parameter int CNT_W = SPI_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DIV_W-1:0] div_i,
    input  logic             cpol_i,
    input  logic             cpha_i,
    input  logic [CNT_W-1:0] nbits_i,
    input  logic             start_i,
    input  logic             abort_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             sclk_o,
    output logic             lead_o,
    output logic             trail_o,
    output logic             shift_o,
    output logic             sample_o
);
    spi_state_e       state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] nbits_q, nbits_d;
    logic [CNT_W:0]   edge_q, edge_d, edge_nxt, edge_end;
    logic             cpol_q, cpol_d, cpha_q, cpha_d;
    logic             sclk_q, sclk_d, done_q, done_d;
    logic             lead_q, lead_d, trail_q, trail_d;
    logic             shift_q, shift_d, sample_q, sample_d;
    logic             idle, accept, wrap;
    assign idle     = (state_q == ST_IDLE);
    assign accept   = idle & start_i & ~abort_i;
    assign edge_nxt = edge_q + 1'b1;
    assign edge_end = {nbits_q, 1'b0};
    spi_tick_counter #(.W(DIV_W)) u_half (
        .clk    (clk),
        .rst    (rst),
        .load_i (idle),
        .en_i   (1'b1),
        .max_i  (div_q),
        .wrap_o (wrap)
    );
    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        nbits_d  = nbits_q;
        cpol_d   = cpol_q;
        cpha_d   = cpha_q;
        edge_d   = edge_q;
        sclk_d   = sclk_q;
        done_d   = 1'b0;
        lead_d   = 1'b0;
        trail_d  = 1'b0;
        shift_d  = 1'b0;
        sample_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                sclk_d = cpol_i;
                if (accept) begin
                    div_d   = div_i;
                    nbits_d = nbits_i;
                    cpol_d  = cpol_i;
                    cpha_d  = cpha_i;
                    edge_d  = '0;
                    state_d = (nbits_i == '0) ? ST_TAIL : ST_RUN;
                    // CPHA=0 presents the first bit before any edge
                    shift_d = ~cpha_i & (nbits_i != '0);
                end
            end
            ST_RUN: if (wrap) begin
                sclk_d   = ~sclk_q;
                edge_d   = edge_nxt;
                lead_d   = edge_nxt[0];
                trail_d  = ~edge_nxt[0];
                shift_d  = cpha_q ? edge_nxt[0] : ~edge_nxt[0] & (edge_nxt != edge_end);
                sample_d = cpha_q ? ~edge_nxt[0] : edge_nxt[0];
                state_d  = (edge_nxt == edge_end) ? ST_TAIL : ST_RUN;
            end
            ST_TAIL: begin
                sclk_d = cpol_q;
                if (wrap) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (abort_i & ~idle) begin
            state_d  = ST_IDLE;
            sclk_d   = cpol_q;
            done_d   = 1'b0;
            lead_d   = 1'b0;
            trail_d  = 1'b0;
            shift_d  = 1'b0;
            sample_d = 1'b0;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            div_q    <= '0;
            nbits_q  <= '0;
            cpol_q   <= 1'b0;
            cpha_q   <= 1'b0;
            edge_q   <= '0;
            sclk_q   <= 1'b0;
            done_q   <= 1'b0;
            lead_q   <= 1'b0;
            trail_q  <= 1'b0;
            shift_q  <= 1'b0;
            sample_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            nbits_q  <= nbits_d;
            cpol_q   <= cpol_d;
            cpha_q   <= cpha_d;
            edge_q   <= edge_d;
            sclk_q   <= sclk_d;
            done_q   <= done_d;
            lead_q   <= lead_d;
            trail_q  <= trail_d;
            shift_q  <= shift_d;
            sample_q <= sample_d;
        end
    end
    assign busy_o   = ~idle;
    assign done_o   = done_q;
    assign sclk_o   = sclk_q;
    assign lead_o   = lead_q;
    assign trail_o  = trail_q;
    assign shift_o  = shift_q;
    assign sample_o = sample_q;
endmodule

// File: tb/tb_spi_sclk_gen.sv
// tb_spi_sclk_gen: directed bursts checked cycle by cycle against an edge-timing model
module tb_spi_sclk_gen;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] div_i = '0;
    logic       cpol_i = 1'b0;
    logic       cpha_i = 1'b0;
    logic [5:0] nbits_i = '0;
    logic       start_i = 1'b0;
    logic       abort_i = 1'b0;
    logic       busy_o, done_o, sclk_o, lead_o, trail_o, shift_o, sample_o;
    int         n_vec = 0;
    int         n_bad = 0;
    spi_sclk_gen dut (
        .clk      (clk),
        .rst      (rst),
        .div_i    (div_i),
        .cpol_i   (cpol_i),
        .cpha_i   (cpha_i),
        .nbits_i  (nbits_i),
        .start_i  (start_i),
        .abort_i  (abort_i),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .sclk_o   (sclk_o),
        .lead_o   (lead_o),
        .trail_o  (trail_o),
        .shift_o  (shift_o),
        .sample_o (sample_o)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask
    // t counts cycles after the start-accept cycle; edge k is expected at t = 1 + k*(d+1)
    task automatic burst(input string tag, input int d, input int c, input int p, input int n,
                         input bit hold, input int stop_t);
        int t, tdone, e, k, bad, ns, nsm;
        bit edg, le, te, she, sae;
        tdone   = 1 + (2 * n + 1) * (d + 1);
        div_i   = d[7:0];
        cpol_i  = c[0];
        cpha_i  = p[0];
        nbits_i = n[5:0];
        start_i = 1'b1;
        t = 0; bad = 0; ns = 0; nsm = 0;
        while (t < tdone && (stop_t == 0 || t < stop_t)) begin
            @(negedge clk);
            t++;
            if (t == 1) begin
                if (!hold) start_i = 1'b0;
                div_i   = 8'($urandom);
                cpol_i  = ~c[0];
                cpha_i  = ~p[0];
                nbits_i = 6'($urandom);
            end
            e   = (t - 1) / (d + 1);
            edg = ((t - 1) % (d + 1) == 0) && e >= 1 && e <= 2 * n;
            le  = edg && e[0];
            te  = edg && !e[0];
            k   = (e > 2 * n) ? 2 * n : e;
            she = p[0] ? le : ((t == 1 && n != 0) || (te && e < 2 * n));
            sae = p[0] ? te : le;
            if (sclk_o !== (c[0] ^ k[0]) || busy_o !== (t < tdone) || done_o !== (t == tdone) ||
                lead_o !== le || trail_o !== te || shift_o !== she || sample_o !== sae) begin
                if (bad == 0)
                    $display("FAIL %s_cycle t=%0d: got sclk%b busy%b done%b lead%b trail%b shift%b sample%b expected %b%b%b%b%b%b%b",
                             tag, t, sclk_o, busy_o, done_o, lead_o, trail_o, shift_o, sample_o,
                             c[0] ^ k[0], t < tdone, t == tdone, le, te, she, sae);
                bad++;
            end
            ns  += int'(shift_o);
            nsm += int'(sample_o);
        end
        chk({tag, "_seq"}, bad, 0);
        if (stop_t == 0) begin
            chk({tag, "_shift_cnt"}, ns, n);
            chk({tag, "_sample_cnt"}, nsm, n);
        end
    endtask
    initial begin
        int dn;
        repeat (3) @(negedge clk);
        chk("reset_outs", {sclk_o, busy_o, done_o, lead_o, trail_o, shift_o, sample_o}, 0);
        rst = 1'b0;
        @(negedge clk);
        burst("d3_c0_p0_n8", 3, 0, 0, 8, 1'b0, 0);
        burst("d0_c1_p1_n16", 0, 1, 1, 16, 1'b0, 0);
        burst("d5_n0", 5, 0, 0, 0, 1'b0, 0);
        burst("d2_c1_p0_n3", 2, 1, 0, 3, 1'b0, 0);
        burst("abort_run", 2, 1, 0, 4, 1'b0, 10);
        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        chk("abort_busy", busy_o, 0);
        chk("abort_sclk", sclk_o, 1);
        chk("abort_strobes", {done_o, lead_o, trail_o, shift_o, sample_o}, 0);
        dn = 0;
        repeat (10) begin
            @(negedge clk);
            dn += int'(done_o) + int'(busy_o);
        end
        chk("abort_quiet", dn, 0);
        burst("post_abort", 2, 0, 1, 4, 1'b0, 0);
        burst("b2b_1", 1, 0, 0, 2, 1'b1, 0);
        burst("b2b_2", 1, 0, 0, 2, 1'b1, 5);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid", {sclk_o, busy_o, done_o, lead_o, trail_o, shift_o, sample_o}, 0);
        start_i = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        burst("max_d255_n63", 255, 0, 0, 63, 1'b0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
